// File: rtl/mem_pkg.sv
// Shared definitions for the memory block reader: default widths, depth and
// the reader FSM state encoding.
package mem_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 8;
  localparam int MEM_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_block_reader.sv
// Read-side controller for the small store/addr memory block. Drives the
// address, waits SETTLE cycles, captures the combinational byte and streams
// it out over valid/ready, folding each transferred byte into an XOR checksum.
module mem_block_reader
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_store,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  // Settle counter compares against this; SETTLE is limited to 1..15.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t            state,       state_nxt;
  logic [ADDR_W-1:0] addr_q,      addr_nxt;
  logic [ADDR_W:0]   remaining_q, remaining_nxt;
  logic [3:0]        settle_q,    settle_nxt;
  logic [DATA_W-1:0] data_q,      data_nxt;
  logic [DATA_W-1:0] ck_q,        ck_nxt;
  logic              valid_q,     valid_nxt;
  logic              xfer;

  assign xfer      = valid_q & out_ready;
  assign mem_addr  = addr_q;
  assign mem_store = 1'b0;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign checksum  = ck_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // State and datapath registers; reset abandons any burst immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      settle_q    <= '0;
      data_q      <= '0;
      ck_q        <= '0;
      valid_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      state       <= state_nxt;
      addr_q      <= addr_nxt;
      remaining_q <= remaining_nxt;
      settle_q    <= settle_nxt;
      data_q      <= data_nxt;
      ck_q        <= ck_nxt;
      valid_q     <= valid_nxt;
    end
  end

  // Next-state and next-datapath logic for the burst sequencer.
  always_comb begin
    // NOTE: hold-value defaults first so no path leaves a signal unassigned (no latches).
    state_nxt     = state;
    addr_nxt      = addr_q;
    remaining_nxt = remaining_q;
    settle_nxt    = settle_q;
    data_nxt      = data_q;
    ck_nxt        = ck_q;
    valid_nxt     = valid_q;

    unique case (state)
      IDLE: begin
        if (start) begin
          ck_nxt = '0;
          if (len == '0) begin
            state_nxt = DONE;
          end else begin
            addr_nxt      = start_addr;
            remaining_nxt = len;
            settle_nxt    = '0;
            state_nxt     = SETUP;
          end
        end
      end

      SETUP: begin
        settle_nxt = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) begin
          data_nxt  = mem_data;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end
      end

      PRESENT: begin
        if (xfer) begin
          ck_nxt        = ck_q ^ data_q;
          remaining_nxt = remaining_q - (ADDR_W + 1)'(1);
          valid_nxt     = 1'b0;
          if (remaining_q == (ADDR_W + 1)'(1)) begin
            state_nxt = DONE;
          end else begin
            // Address wraps naturally modulo the memory depth.
            addr_nxt   = addr_q + ADDR_W'(1);
            settle_nxt = '0;
            state_nxt  = SETUP;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_block_reader.md
Name: mem_block_reader

Overview:
- Read-side controller for the 4-entry x 8-bit store/addr memory block.
- Drives the memory's addr and store inputs and samples its combinational byte output.
- Streams a burst of consecutive entries to a downstream consumer over a valid/ready handshake.
- Accumulates an XOR checksum over the burst and pulses done at the end.

Parameters:
- ADDR_W, 2, memory address width; depth = 2**ADDR_W.
- DATA_W, 8, memory word width.
- SETTLE, 1, cycles the address is held before capturing mem_data (range 1..15).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- start, input, 1, begin a burst; sampled only in IDLE.
- start_addr, input, ADDR_W, first address of the burst; sampled with start.
- len, input, ADDR_W+1, number of entries to read (0..2**ADDR_W); sampled with start.
- mem_addr, output, ADDR_W, address to the memory block.
- mem_store, output, 1, store strobe to the memory block; constant 0, the reader never writes.
- mem_data, input, DATA_W, byte returned by the memory block for mem_addr.
- out_data, output, DATA_W, captured byte.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, consumer accepts out_data.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse when the burst completes.
- checksum, output, DATA_W, XOR of all bytes transferred in the last burst; held until next start.

Behaviour:
- Reset values: mem_addr=0, mem_store=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0, state=IDLE, counters=0.
- Reset takes effect asynchronously and may occur mid-burst: the burst is abandoned, no done pulse is produced, and out_valid drops immediately.
- IDLE:
  - start=1 with len=0: go to DONE; checksum cleared to 0.
  - start=1 with len>0: latch start_addr into mem_addr, load remaining=len, clear checksum, clear settle counter, go to SETUP.
  - start=0: stay in IDLE.
- SETUP:
  - mem_addr is held stable; the settle counter increments each cycle.
  - On the edge where the counter reaches SETTLE-1: out_data<=mem_data, out_valid<=1, go to PRESENT.
  - With SETTLE=1, out_valid rises exactly 1 cycle after the address is first driven.
- PRESENT:
  - out_valid stays high and out_data stays stable until out_ready=1. A transfer occurs on an edge with out_valid&out_ready.
  - On a transfer: checksum<=checksum^out_data, remaining decrements, out_valid<=0.
  - If remaining was 1, go to DONE. Otherwise mem_addr<=mem_addr+1 (wraps modulo 2**ADDR_W, so 3->0 for ADDR_W=2), clear the settle counter, go to SETUP.
  - Back-to-back throughput with SETTLE=1 and out_ready held high: one byte every 2 cycles.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE. checksum is final and stable from the cycle done is high.
- start while busy: ignored, with no effect on the current burst.
- start coincident with the DONE cycle: ignored; it must be reasserted once in IDLE.
- out_ready while out_valid=0: ignored.
- len > 2**ADDR_W: not possible, since len width caps it at 2**ADDR_W; a full-depth burst reads every entry exactly once.
- mem_addr changes only in IDLE on start, or on a PRESENT transfer; never while out_valid=1.

Decomposition:
- Shared package mem_pkg:
  - ADDR_W and DATA_W defaults.
  - State encoding constants IDLE=2'd0, SETUP=2'd1, PRESENT=2'd2, DONE=2'd3.
  - Depth constant MEM_DEPTH=4.
- Sub-module: none required.
- The integration top connects this block to the memory block: mem_addr->addr, mem_store->store, memory->mem_data.

Test Plan:
- Preload the memory with 0x11, 0x22, 0x44, 0x88. Pulse start with start_addr=0, len=4, out_ready held 1 -> out_data sequence 0x11, 0x22, 0x44, 0x88, one transfer every 2 cycles, done pulse once, checksum=0xFF.
- Wrap-around: start_addr=3, len=2 -> mem_addr goes 3 then 0; out_data 0x88 then 0x11; checksum=0x99.
- Backpressure: len=2, out_ready held low for 5 cycles after out_valid rises -> out_valid and out_data=0x11 stay stable throughout with mem_addr unchanged; exactly 2 transfers occur; checksum=0x33.
- len=0 with start -> no out_valid; done pulses 1 cycle after start is sampled; checksum=0x00; busy high for 1 cycle.
- Reset mid-burst: assert reset while in PRESENT with out_valid=1 -> all outputs return to reset values immediately with no done pulse. A new start with start_addr=0, len=1 then yields 0x11 and checksum=0x11.
- start pulsed again while busy with a different start_addr -> the ongoing burst completes unaltered, and no second burst starts after done.
